// File: rtl/bm_pkg.sv
// Shared definitions for the Bomberman sprite datapath: life-sequencer states
// and the death-ROM addressing constants.
package bm_pkg;

    typedef enum logic [2:0] {
        ALIVE    = 3'd0,
        DYING    = 3'd1,
        RESPAWN  = 3'd2,
        INVULN   = 3'd3,
        GAMEOVER = 3'd4
    } life_state_t;

    localparam int DEATH_FRAMES       = 5;
    localparam int SPRITE_FRAME_WORDS = 384;  // 16x24 sprite

    localparam logic [2:0]  DEATH_LAST_FRAME  = 3'(DEATH_FRAMES - 1);
    localparam logic [11:0] DEATH_LAST_OFFSET = 12'((DEATH_FRAMES - 1) * SPRITE_FRAME_WORDS);

    function automatic logic [11:0] death_rom_offset(input logic [2:0] frame_idx);
        return 12'(frame_idx) * 12'(SPRITE_FRAME_WORDS);
    endfunction

endpackage

// File: rtl/bm_cycle_timer.sv
// Free-running 0..TERMINAL-1 counter with synchronous clear; done is high for
// the single enabled cycle in which the count sits at its terminal value.
module bm_cycle_timer #(
    parameter int TERMINAL = 4,
    parameter int WIDTH    = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL - 1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + WIDTH'(1);
        end
    end

    // Deliberately not gated by clear: clear is derived from the next state,
    // which itself depends on done.
    assign done = enable && (count == LAST);

endmodule

// File: rtl/bm_life_ctrl.sv
// Player-life sequencer: owns lives/gameover, drives the death animation,
// the respawn pulse and the post-respawn invulnerability blink.
module bm_life_ctrl
    import bm_pkg::*;
#(
    parameter int LIVES_INIT         = 3,
    parameter int LIVES_MAX          = 5,
    parameter int DEATH_FRAME_CYCLES = 12500000,
    parameter int INVULN_CYCLES      = 100000000,
    parameter int BLINK_CYCLES       = 6250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hit,
    input  logic        extra_life,
    input  logic        restart,
    output logic [2:0]  lives,
    output logic        gameover,
    output logic        motion_en,
    output logic        death_on,
    output logic [11:0] death_offset,
    output logic        sprite_hide,
    output logic        invuln,
    output logic        respawn
);

    localparam int MAX_A   = (DEATH_FRAME_CYCLES > BLINK_CYCLES) ? DEATH_FRAME_CYCLES : BLINK_CYCLES;
    localparam int MAX_CYC = (INVULN_CYCLES > MAX_A) ? INVULN_CYCLES : MAX_A;
    localparam int TW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    localparam logic [2:0] LIVES_INIT_L = 3'(LIVES_INIT);
    localparam logic [2:0] LIVES_MAX_L  = 3'(LIVES_MAX);

    life_state_t state, state_next;
    logic [2:0]  lives_next;
    logic [2:0]  frame_idx, frame_next;
    logic        frame_done, invuln_done, blink_done;
    logic        timer_clear;
    logic        last_frame_done;
    logic        dec;

    bm_cycle_timer #(.TERMINAL(DEATH_FRAME_CYCLES), .WIDTH(TW)) u_frame_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (state == DYING),
        .done   (frame_done)
    );

    bm_cycle_timer #(.TERMINAL(INVULN_CYCLES), .WIDTH(TW)) u_invuln_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (state == INVULN),
        .done   (invuln_done)
    );

    bm_cycle_timer #(.TERMINAL(BLINK_CYCLES), .WIDTH(TW)) u_blink_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (state == INVULN),
        .done   (blink_done)
    );

    // Every state entry restarts all timers.
    assign timer_clear = (state_next != state);

    always_comb begin
        lives_next      = lives;
        state_next      = state;
        frame_next      = frame_idx;
        last_frame_done = (state == DYING) && frame_done && (frame_idx == DEATH_LAST_FRAME);
        dec             = last_frame_done && (lives != 3'd0);

        // Lives first: the end-of-animation branch depends on the result.
        if (state == GAMEOVER) begin
            if (restart) lives_next = LIVES_INIT_L;
        end else if (dec && extra_life) begin
            lives_next = lives;
        end else if (dec) begin
            lives_next = lives - 3'd1;
        end else if (extra_life && (lives < LIVES_MAX_L)) begin
            lives_next = lives + 3'd1;
        end

        case (state)
            ALIVE: begin
                if (hit) begin
                    state_next = DYING;
                    frame_next = 3'd0;
                end
            end
            DYING: begin
                if (last_frame_done) begin
                    state_next = (lives_next == 3'd0) ? GAMEOVER : RESPAWN;
                end else if (frame_done) begin
                    frame_next = frame_idx + 3'd1;
                end
            end
            RESPAWN: state_next = INVULN;
            INVULN: begin
                if (invuln_done) state_next = ALIVE;
            end
            GAMEOVER: begin
                if (restart) begin
                    state_next = ALIVE;
                    frame_next = 3'd0;
                end
            end
            default: state_next = ALIVE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ALIVE;
            lives     <= LIVES_INIT_L;
            frame_idx <= 3'd0;
        end else begin
            state     <= state_next;
            lives     <= lives_next;
            frame_idx <= frame_next;
        end
    end

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gameover     <= 1'b0;
            motion_en    <= 1'b1;
            death_on     <= 1'b0;
            death_offset <= 12'd0;
            sprite_hide  <= 1'b0;
            invuln       <= 1'b0;
            respawn      <= 1'b0;
        end else begin
            gameover     <= (state_next == GAMEOVER);
            motion_en    <= (state_next == ALIVE) || (state_next == INVULN);
            death_on     <= (state_next == DYING) || (state_next == GAMEOVER);
            death_offset <= (state_next == DYING)    ? death_rom_offset(frame_next) :
                            (state_next == GAMEOVER) ? DEATH_LAST_OFFSET : 12'd0;
            sprite_hide  <= ((state_next == INVULN) && (state == INVULN)) ? (sprite_hide ^ blink_done) : 1'b0;
            invuln       <= (state_next == INVULN);
            respawn      <= (state_next == RESPAWN);
        end
    end

endmodule
